// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC write scheduler.
// ST_GAP exists only when DAC_SCHED_HOLDOFF_EN is defined.
package dac_pkg;

    localparam int unsigned DAC_W            = 8;
    localparam int unsigned DAC_FRAME_CYCLES = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef DAC_SCHED_HOLDOFF_EN
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
`else
        ST_SHIFT = 2'd2
`endif
    } dac_state_e;

    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned n);
        return ((32'(idx) + 32'd1) >= n) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dac_sched_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arb #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    function automatic int unsigned rr_dist(input int unsigned j, input int unsigned p);
        return (j >= p) ? (j - p) : (j + N_REQ - p);
    endfunction

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Outer loop is the priority distance from the pointer, so the first hit wins.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!valid_o && req_i[j] && (rr_dist(j, 32'(ptr_i)) == k)) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dac_sched.sv
// DAC write scheduler: round-robin grant, one serializer frame per grant.
// Optional post-frame holdoff (GAP state) with macro DAC_SCHED_HOLDOFF_EN.
module dac_sched
    import dac_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FRAME_CYCLES = DAC_FRAME_CYCLES,
    parameter int unsigned HOLDOFF      = 3
) (
    input  logic                   clk20,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [DAC_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [DAC_W-1:0]       data_spi,
    output logic                   start,
    output logic                   busy,
    output logic [2:0]             grant_id
);

`ifdef DAC_SCHED_HOLDOFF_EN
    localparam int unsigned CNT_MAX = (FRAME_CYCLES > HOLDOFF) ? FRAME_CYCLES : HOLDOFF;
`else
    localparam int unsigned CNT_MAX = FRAME_CYCLES;
    // HOLDOFF has no effect in this build.
    logic holdoff_unused;
    assign holdoff_unused = (HOLDOFF != 0);
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX);

    dac_state_e          state_q;
    logic [2:0]          ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_REQ-1:0]    ack_q;
    logic [DAC_W-1:0]    data_q;
    logic                start_q;
    logic                busy_q;
    logic [2:0]          gid_q;

    logic [N_REQ-1:0]    arb_gnt;
    logic [2:0]          arb_idx;
    logic                arb_valid;
    logic                arb_en;
    logic                grant_now;
    logic [DAC_W-1:0]    sel_data;

    rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // The last cycle of SHIFT/GAP arbitrates like IDLE so back-to-back frames lose no cycle.
    always_comb begin
        arb_en = 1'b0;
        case (state_q)
            ST_IDLE:  arb_en = 1'b1;
`ifdef DAC_SCHED_HOLDOFF_EN
            ST_SHIFT: arb_en = 1'b0;
            ST_GAP:   arb_en = (cnt_q == '0);
`else
            ST_SHIFT: arb_en = (cnt_q == '0);
`endif
            default:  arb_en = 1'b0;
        endcase
        grant_now = arb_en && arb_valid;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (arb_idx == 3'(j)) begin
                sel_data = req_data[DAC_W*j +: DAC_W];
            end
        end
    end

    always_ff @(posedge clk20) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            ack_q   <= '0;
            start_q <= 1'b0;
            if (grant_now) begin
                state_q <= ST_LOAD;
                ack_q   <= arb_gnt;
                data_q  <= sel_data;
                gid_q   <= arb_idx;
                busy_q  <= 1'b1;
                ptr_q   <= rr_next(arb_idx, N_REQ);
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        start_q <= 1'b1;
                        cnt_q   <= CNT_W'(FRAME_CYCLES - 2);
                        state_q <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (cnt_q == '0) begin
`ifdef DAC_SCHED_HOLDOFF_EN
                            cnt_q   <= CNT_W'(HOLDOFF - 1);
                            state_q <= ST_GAP;
`else
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
`ifdef DAC_SCHED_HOLDOFF_EN
                    ST_GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack      = ack_q;
    assign data_spi = data_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: doc/dac_sched.md
DAC_SCHED -- requirements
Module: dac_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter FRAME_CYCLES, default 17, minimum clk20 cycles from one start pulse to the next (16 shift cycles plus 1 deselect cycle).
REQ-003 The block SHALL have parameter HOLDOFF, default 3, extra idle cycles after each frame; it is used only when DAC_SCHED_HOLDOFF_EN is defined.
REQ-004 The block SHALL have port clk20, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ, per-requester write request, level, held until acked.
REQ-007 The block SHALL have port req_data, input, 8*N_REQ, DAC code per requester; requester i drives bits [8i+7:8i].
REQ-008 The block SHALL have port ack, output, N_REQ, one-cycle pulse to the granted requester when its data is captured.
REQ-009 The block SHALL have port data_spi, output, 8, DAC code presented to the serializer.
REQ-010 The block SHALL have port start, output, 1, one-cycle serializer load pulse.
REQ-011 The block SHALL have port busy, output, 1, high from the grant cycle until the block returns to IDLE.
REQ-012 The block SHALL have port grant_id, output, 3, index of the requester owning the current frame.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-014 In IDLE with any req bit high, the block SHALL grant round-robin, starting the search at the index after the last grant (after reset, index 0), and enter LOAD next cycle.
REQ-015 In the grant cycle, the block SHALL pulse ack[grant] for exactly one cycle, register req_data of the granted requester into data_spi, set grant_id and assert busy.
REQ-016 In LOAD, start SHALL be high for exactly one cycle with data_spi stable; start is never high in any other state.
REQ-017 data_spi SHALL hold its value from LOAD until the next grant.
REQ-018 SHIFT SHALL last FRAME_CYCLES-1 cycles, counted by a down-counter loaded in LOAD.
REQ-019 SHIFT SHALL go to GAP if the holdoff feature is compiled in, else to IDLE.
REQ-020 Two consecutive start pulses SHALL be at least FRAME_CYCLES cycles apart (FRAME_CYCLES+HOLDOFF with the holdoff feature), even with requests continuously pending.
REQ-021 A grant in IDLE SHALL happen in the same cycle IDLE is entered from SHIFT/GAP if any req is high, i.e. no dead cycle beyond REQ-020.
REQ-022 The block SHALL sample req only in IDLE; requests raised or dropped during a frame SHALL not affect it.
REQ-023 A requester that drops req before grant SHALL not be acked.
REQ-024 The round-robin pointer SHALL wrap from N_REQ-1 to 0.

Reset
REQ-025 On rst high at a clock edge the block SHALL enter IDLE and clear ack, start, busy, data_spi (0x00), grant_id (0) and the counter, and set the RR pointer so index 0 has first priority.
REQ-026 rst in any state SHALL abort the frame with no further start or ack; a frame cut short is not retried.

Configuration
REQ-027 With macro DAC_SCHED_HOLDOFF_EN defined, the block SHALL include GAP, lasting HOLDOFF cycles with busy high, then IDLE.
REQ-028 Without DAC_SCHED_HOLDOFF_EN, the block SHALL have no GAP state or logic and the HOLDOFF parameter SHALL be ignored.

Structure
REQ-029 The block SHALL take the state encoding enum, default FRAME_CYCLES and the DAC code width (8) from the shared package dac_pkg.
REQ-030 The round-robin arbiter SHALL be the sub-module rr_arb (request vector and pointer in, one-hot grant and index out); the rest is flat.

Verification
REQ-031 After reset with req=0001 and data0=0xA5, the bench SHALL see ack[0] pulse, then start one cycle later with data_spi=0xA5, and busy low after 17 cycles.
REQ-032 With req=1111 held, the bench SHALL see grants in order 0,1,2,3,0 and start pulses exactly 17 cycles apart (20 with holdoff, HOLDOFF=3).
REQ-033 With req[2] raised mid-frame of requester 0, the bench SHALL see the frame unchanged and the next grant to 2 at the first IDLE cycle.
REQ-034 With rst asserted 5 cycles into SHIFT, the bench SHALL see busy=0, start=0, data_spi=0x00 the next cycle, and the next grant to index 0.
REQ-035 With req[1] high 1 cycle during a frame then dropped, the bench SHALL see no ack[1] ever.
REQ-036 For every frame, a checker of the serializer outputs SHALL see the 16 bits as 0000, code MSB first, then 0000, and the deselect line high at least 1 cycle between frames.
